sevseg_scan_arbiter: RTL and testbench
======================================

SEVSEG_SCAN_ARBITER -- requirements
Module: sevseg_scan_arbiter

Interface
REQ-001 Parameter NUM_DIGITS, 8, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter BLANK_CYCLES, 1, all-anodes-off cycles after each digit (anti-ghosting); 0 means no blank state.
REQ-003 Parameter HOLD_FRAMES, 4, consecutive frame boundaries with dbg_req low before ownership returns to mmio; legal range 1..255.
REQ-004 clk_7seg  in  1  scan clock; one digit slot per cycle.
REQ-005 Rst  in  1  reset; synchronous, active-high, sampled on clk_7seg.
REQ-006 dbg_req  in  1  debug/prog source requests the display.
REQ-007 dbg_data  in  32  debug value (8 hex nibbles).
REQ-008 mmio_req  in  1  MMIO display source valid.
REQ-009 mmio_data  in  32  MMIO display value.
REQ-010 an  out  NUM_DIGITS  anode enables, active-low.
REQ-011 sev_out  out  7  segments, active-low, codebase hex encoding.
REQ-012 owner  out  1  1 = debug source owns the frame; 0 = MMIO source.
REQ-013 frame_done  out  1  one-cycle pulse when the last digit's slot, including its blank, completes.

Function
REQ-014 FSM states: IDLE, DRIVE, BLANK.
- IDLE: lasts one cycle after reset and performs a frame boundary; next state is DRIVE, idx=0.
REQ-015 DRIVE: an = all ones except bit idx low; sev_out = decode(frame[4*idx+3:4*idx]).
- Next state is BLANK if BLANK_CYCLES>0, else advance idx.
REQ-016 BLANK: an = all ones; sev_out = 7'h7F.
- Lasts exactly BLANK_CYCLES cycles, then advances idx.
REQ-017 Advance: idx = idx+1.
- If idx == NUM_DIGITS-1: wrap idx to 0, pulse frame_done, perform a frame boundary.
REQ-018 Frame period is NUM_DIGITS*(1+BLANK_CYCLES) cycles; default 16.
REQ-019 Frame boundary: arbitrate first, then latch the winner's data into frame.
- frame holds constant for the whole frame (no tearing); input changes mid-frame are ignored.
REQ-020 Arbitration, when dbg_req=1 at a boundary: owner becomes 1 and hold counter clears.
REQ-021 Arbitration, when owner=1 and dbg_req=0: hold counter increments.
- owner switches to 0 at the boundary where the counter reaches HOLD_FRAMES, and the counter then clears.
REQ-022 Arbitration, when owner=0: frame latches mmio_data if mmio_req=1; otherwise frame keeps its previous value.
REQ-023 Decode table: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
REQ-024 Decode table: 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
REQ-025 Digits idx >= NUM_DIGITS never drive; only frame[4*NUM_DIGITS-1:0] is displayed.

Reset
REQ-026 Rst=1 at any edge, including mid-frame, forces IDLE at that edge.
REQ-027 Reset values: an all ones, sev_out 7'h7F, owner 0, frame_done 0, frame 0, idx 0, hold counter 0.
REQ-028 The first DRIVE cycle follows the IDLE cycle that comes after Rst deasserts.

Configuration
REQ-029 Macro SEVSEG_LZ_BLANK_EN, when defined: digits above the most-significant non-zero nibble of frame output 7'h7F while their anode is still driven.
- Digit 0 is always decoded.
- frame=0 shows a single "0".
REQ-030 Without SEVSEG_LZ_BLANK_EN: every digit is decoded, including leading zeros.

Verification
REQ-031 Defaults; mmio_req=1, mmio_data=32'h1234ABCD; release Rst -> an cycles FE,FF,FD,FF,...,7F,FF.
- sev_out on D slot = 1000010, on 1 slot = 1001111.
- frame_done pulses every 16 cycles.
REQ-032 Change mmio_data to 32'h0 mid-frame -> current frame still shows 1234ABCD; the next frame shows zeros.
REQ-033 Raise dbg_req with dbg_data=32'hDEADBEEF mid-frame -> owner=1 and DEADBEEF shown from the next boundary.
- Drop dbg_req -> owner returns to 0 at the 4th subsequent boundary.
REQ-034 Assert Rst during the digit-5 DRIVE cycle -> next cycle an=FF, sev_out=7F, owner=0.
- After release, scanning restarts at digit 0.
REQ-035 SEVSEG_LZ_BLANK_EN defined, mmio_data=32'h000000A5 -> digits 7..2 output 7F with anodes active.
- Digit1 = 0001000, digit0 = 0100100.
- Without the macro, digits 7..2 output 0000001.
REQ-036 BLANK_CYCLES=0, NUM_DIGITS=4 -> an sequence E,D,B,7 with no FF slots; frame_done every 4 cycles.

Source files
------------

// File: rtl/sevseg_scan_arbiter_if.sv
// Display-source and scan-output bundle for sevseg_scan_arbiter.
// master = sources/observer side, slave = the arbiter itself.
interface sevseg_scan_arbiter_if #(
  parameter int NUM_DIGITS = 8
);
  logic                  dbg_req;
  logic [31:0]           dbg_data;
  logic                  mmio_req;
  logic [31:0]           mmio_data;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            sev_out;
  logic                  owner;
  logic                  frame_done;

  modport master (
    output dbg_req, dbg_data, mmio_req, mmio_data,
    input  an, sev_out, owner, frame_done
  );

  modport slave (
    input  dbg_req, dbg_data, mmio_req, mmio_data,
    output an, sev_out, owner, frame_done
  );
endinterface

// File: rtl/sevseg_scan_arbiter.sv
// Multiplexed 7-seg scanner arbitrating a debug and an MMIO source per frame.
// Optional macro SEVSEG_LZ_BLANK_EN blanks leading-zero digits (anodes still driven).

module sevseg_digit_dec (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    if (!blank) begin
      case (nib)
        4'h0: seg = 7'b0000001;
        4'h1: seg = 7'b1001111;
        4'h2: seg = 7'b0010010;
        4'h3: seg = 7'b0000110;
        4'h4: seg = 7'b1001100;
        4'h5: seg = 7'b0100100;
        4'h6: seg = 7'b0100000;
        4'h7: seg = 7'b0001111;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0000100;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b1100000;
        4'hC: seg = 7'b0110001;
        4'hD: seg = 7'b1000010;
        4'hE: seg = 7'b0110000;
        default: seg = 7'b0111000;
      endcase
    end
  end
endmodule

module sevseg_scan_arbiter #(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 1,
  parameter int HOLD_FRAMES  = 4
) (
  input  logic                  clk_7seg,
  input  logic                  Rst,
  sevseg_scan_arbiter_if.slave  bus
);
  localparam int             IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int             BW       = $clog2(BLANK_CYCLES + 2);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0]  LAST_BLK = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [7:0]     HOLD_LIM = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  state_t                         state, state_nxt;
  logic [IW-1:0]                  idx;
  logic [BW-1:0]                  bcnt;
  logic [31:0]                    frame;
  logic                           owner;
  logic [7:0]                     hold;
  logic [7:0]                     hold_nxt;
  logic                           advance, last_slot, boundary;
  logic [NUM_DIGITS-1:0]          lz_blank;
  logic [NUM_DIGITS-1:0][6:0]     dig_seg;

  always_comb begin
    advance = 1'b0;
    if (state == DRIVE)      advance = (BLANK_CYCLES == 0);
    else if (state == BLANK) advance = (bcnt == LAST_BLK);
    last_slot = advance && (idx == LAST_IDX);
    boundary  = (state == IDLE) || last_slot;
    hold_nxt  = hold + 8'd1;
  end

  always_ff @(posedge clk_7seg) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = DRIVE;
      DRIVE:   state_nxt = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
      BLANK:   if (bcnt == LAST_BLK) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan position plus frame arbitration; frame only changes at a boundary.
  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      idx   <= '0;
      bcnt  <= '0;
      frame <= '0;
      owner <= 1'b0;
      hold  <= '0;
    end else begin
      if (state == BLANK && !advance) bcnt <= bcnt + 1'b1;
      else                            bcnt <= '0;

      if (state == IDLE || last_slot) idx <= '0;
      else if (advance)               idx <= idx + 1'b1;

      if (boundary) begin
        if (bus.dbg_req) begin
          owner <= 1'b1;
          hold  <= '0;
          frame <= bus.dbg_data;
        end else if (owner) begin
          // Debug keeps its last frame on screen until the hold expires.
          if (hold_nxt == HOLD_LIM) begin
            owner <= 1'b0;
            hold  <= '0;
            if (bus.mmio_req) frame <= bus.mmio_data;
          end else begin
            hold <= hold_nxt;
          end
        end else if (bus.mmio_req) begin
          frame <= bus.mmio_data;
        end
      end
    end
  end

`ifdef SEVSEG_LZ_BLANK_EN
  logic [IW-1:0] msnz;
  always_comb begin
    msnz = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (frame[4*i +: 4] != 4'h0) msnz = IW'(i);
  end
  always_comb begin
    lz_blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) lz_blank[i] = (IW'(i) > msnz);
  end
`else
  assign lz_blank = '0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    sevseg_digit_dec u_dec (
      .nib   (frame[4*g +: 4]),
      .blank (lz_blank[g]),
      .seg   (dig_seg[g])
    );
  end

  always_comb begin
    bus.an         = '1;
    bus.sev_out    = 7'h7F;
    bus.frame_done = last_slot;
    if (state == DRIVE) begin
      bus.an      = ~(NUM_DIGITS'(1) << idx);
      bus.sev_out = dig_seg[idx];
    end
  end

  assign bus.owner = owner;
endmodule

// File: tb/tb_sevseg_scan_arbiter.sv
// Directed bench for sevseg_scan_arbiter: scan order, frame latching, arbitration, reset.
module tb_sevseg_scan_arbiter;
  logic clk_7seg = 1'b0;
  logic Rst      = 1'b1;
  always #5 clk_7seg = ~clk_7seg;

  sevseg_scan_arbiter_if #(.NUM_DIGITS(8)) bus ();
  sevseg_scan_arbiter_if #(.NUM_DIGITS(4)) bus2 ();

  sevseg_scan_arbiter #(.NUM_DIGITS(8), .BLANK_CYCLES(1), .HOLD_FRAMES(4)) dut (
    .clk_7seg (clk_7seg),
    .Rst      (Rst),
    .bus      (bus)
  );

  sevseg_scan_arbiter #(.NUM_DIGITS(4), .BLANK_CYCLES(0), .HOLD_FRAMES(4)) dut2 (
    .clk_7seg (clk_7seg),
    .Rst      (Rst),
    .bus      (bus2)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_an;
  logic [6:0] exp_sv;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] f, input int i);
`ifdef SEVSEG_LZ_BLANK_EN
    int top = 0;
    for (int j = 1; j < 8; j++) if (f[4*j +: 4] != 4'h0) top = j;
    if (i > top) return 7'h7F;
`endif
    return dec(f[4*i +: 4]);
  endfunction

  task automatic test_reset();
    bus.dbg_req = 1'b0;  bus.dbg_data = 32'h0;
    bus.mmio_req = 1'b0; bus.mmio_data = 32'h0;
    bus2.dbg_req = 1'b0; bus2.dbg_data = 32'h0;
    bus2.mmio_req = 1'b1; bus2.mmio_data = 32'h0000_4321;
    Rst = 1'b1;
    repeat (3) @(negedge clk_7seg);
    checks++;
    if (bus.an !== 8'hFF || bus.sev_out !== 7'h7F || bus.owner !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: an=%h sev=%h owner=%b fd=%b want an=ff sev=7f owner=0 fd=0",
               bus.an, bus.sev_out, bus.owner, bus.frame_done);
    end
    checks++;
    if (bus2.an !== 4'hF || bus2.sev_out !== 7'h7F) begin
      errors++;
      $display("FAIL reset2: an=%h sev=%h want an=f sev=7f", bus2.an, bus2.sev_out);
    end
  endtask

  task automatic test_scan();
    bus.mmio_req = 1'b1; bus.mmio_data = 32'h1234ABCD;
    Rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_7seg);
      exp_an = (k % 2 == 0) ? ~(8'd1 << (k / 2)) : 8'hFF;
      exp_sv = (k % 2 == 0) ? exp_seg(32'h1234ABCD, k / 2) : 7'h7F;
      checks++;
      if (bus.an !== exp_an || bus.sev_out !== exp_sv || bus.frame_done !== (k == 15)) begin
        errors++;
        $display("FAIL scan slot %0d: an=%h sev=%b fd=%b want an=%h sev=%b fd=%b",
                 k, bus.an, bus.sev_out, bus.frame_done, exp_an, exp_sv, k == 15);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_7seg);
      if (k == 0) bus.mmio_data = 32'h0;
      exp_an = (k % 2 == 0) ? ~(8'd1 << (k / 2)) : 8'hFF;
      exp_sv = (k % 2 == 0) ? exp_seg(32'h1234ABCD, k / 2) : 7'h7F;
      checks++;
      if (bus.an !== exp_an || bus.sev_out !== exp_sv) begin
        errors++;
        $display("FAIL no_tear slot %0d: an=%h sev=%b want an=%h sev=%b", k, bus.an, bus.sev_out, exp_an, exp_sv);
      end
    end
    for (int k = 0; k < 16; k += 2) begin
      @(negedge clk_7seg);
      exp_sv = exp_seg(32'h0, k / 2);
      checks++;
      if (bus.sev_out !== exp_sv) begin
        errors++;
        $display("FAIL zero_frame digit %0d: sev=%b want %b", k / 2, bus.sev_out, exp_sv);
      end
      @(negedge clk_7seg);
    end
  endtask

  task automatic test_leading_zero();
    bus.mmio_data = 32'h0000_00A5;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_7seg);
      exp_an = (k % 2 == 0) ? ~(8'd1 << (k / 2)) : 8'hFF;
      exp_sv = (k % 2 == 0) ? exp_seg(32'h0000_00A5, k / 2) : 7'h7F;
      checks++;
      if (bus.an !== exp_an || bus.sev_out !== exp_sv) begin
        errors++;
        $display("FAIL lz slot %0d: an=%h sev=%b want an=%h sev=%b", k, bus.an, bus.sev_out, exp_an, exp_sv);
      end
    end
  endtask

  task automatic test_debug_arb();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_7seg);
      if (k == 5) begin bus.dbg_req = 1'b1; bus.dbg_data = 32'hDEADBEEF; end
    end
    checks++;
    if (bus.owner !== 1'b0) begin
      errors++;
      $display("FAIL dbg_midframe owner=%b want 0", bus.owner);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_7seg);
      if (k == 0) begin
        checks++;
        if (bus.owner !== 1'b1) begin
          errors++;
          $display("FAIL dbg_take owner=%b want 1", bus.owner);
        end
        bus.dbg_req = 1'b0; bus.dbg_data = 32'h0;
      end
      if (k % 2 == 0) begin
        exp_sv = exp_seg(32'hDEADBEEF, k / 2);
        checks++;
        if (bus.sev_out !== exp_sv) begin
          errors++;
          $display("FAIL dbg_frame digit %0d: sev=%b want %b", k / 2, bus.sev_out, exp_sv);
        end
      end
    end
    for (int b = 1; b <= 4; b++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk_7seg);
        if (k == 0) begin
          checks++;
          if (bus.owner !== (b < 4)) begin
            errors++;
            $display("FAIL hold boundary %0d: owner=%b want %b", b, bus.owner, b < 4);
          end
        end
        if (b == 4 && k % 2 == 0) begin
          exp_sv = exp_seg(32'h0000_00A5, k / 2);
          checks++;
          if (bus.sev_out !== exp_sv) begin
            errors++;
            $display("FAIL mmio_return digit %0d: sev=%b want %b", k / 2, bus.sev_out, exp_sv);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bus.dbg_req = 1'b1; bus.dbg_data = 32'hDEADBEEF;
    for (int k = 0; k <= 10; k++) @(negedge clk_7seg);
    checks++;
    if (bus.an !== 8'hDF || bus.owner !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: an=%h owner=%b want an=df owner=1", bus.an, bus.owner);
    end
    Rst = 1'b1; bus.dbg_req = 1'b0;
    @(negedge clk_7seg);
    checks++;
    if (bus.an !== 8'hFF || bus.sev_out !== 7'h7F || bus.owner !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: an=%h sev=%h owner=%b fd=%b want an=ff sev=7f owner=0 fd=0",
               bus.an, bus.sev_out, bus.owner, bus.frame_done);
    end
    Rst = 1'b0;
    @(negedge clk_7seg);
    checks++;
    if (bus.an !== 8'hFE || bus.sev_out !== exp_seg(32'h0000_00A5, 0) || bus.owner !== 1'b0) begin
      errors++;
      $display("FAIL restart: an=%h sev=%b owner=%b want an=fe sev=%b owner=0",
               bus.an, bus.sev_out, bus.owner, exp_seg(32'h0000_00A5, 0));
    end
  endtask

  task automatic test_mmio_noreq();
    bus.mmio_req = 1'b0; bus.mmio_data = 32'h8888_8888;
    for (int k = 1; k < 16; k++) @(negedge clk_7seg);
    for (int k = 0; k < 4; k += 2) begin
      @(negedge clk_7seg);
      exp_sv = exp_seg(32'h0000_00A5, k / 2);
      checks++;
      if (bus.sev_out !== exp_sv) begin
        errors++;
        $display("FAIL noreq_keep digit %0d: sev=%b want %b", k / 2, bus.sev_out, exp_sv);
      end
      @(negedge clk_7seg);
    end
    bus.mmio_req = 1'b1;
  endtask

  task automatic test_no_blank();
    logic [3:0] e_an;
    Rst = 1'b1;
    @(negedge clk_7seg);
    Rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_7seg);
      e_an   = ~(4'd1 << (k % 4));
      exp_sv = dec(4'((k % 4) + 1));
      checks++;
      if (bus2.an !== e_an || bus2.sev_out !== exp_sv || bus2.frame_done !== (k % 4 == 3)) begin
        errors++;
        $display("FAIL noblank slot %0d: an=%h sev=%b fd=%b want an=%h sev=%b fd=%b",
                 k, bus2.an, bus2.sev_out, bus2.frame_done, e_an, exp_sv, k % 4 == 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_frame_change();
    test_leading_zero();
    test_debug_arb();
    test_reset_mid_frame();
    test_mmio_noreq();
    test_no_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
